// File: rtl/memblock_pkg.sv
// Shared types and helpers for the multi-port memory block.
package memblock_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int MAX_W   = 256;
  localparam int MAX_NBE = MAX_W / 8;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers widen their words to MAX_W and cast the result back down.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]   old_w,
                                                  input logic [MAX_W-1:0]   new_w,
                                                  input logic [MAX_NBE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_NBE; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/memblock_mp_rdport.sv
// One read path: range check, zero register, write bypass and optional output register.
module memblock_mp_rdport
  import memblock_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int NBE     = WIDTH / 8,
  parameter int REG_RD  = 0,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             wr_ok,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_din,
  input  logic [NBE-1:0]   wr_be,
  output logic [WIDTH-1:0] rd_dout
);

  logic             in_rng;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rd_q;

  if (DEPTH == (1 << AW)) begin : g_full
    assign in_rng = 1'b1;
  end else begin : g_part
    assign in_rng = (32'(rd_addr) < DEPTH);
  end

  always_comb begin
    rd_val = '0;
    if (!clear && in_rng && !((ZERO_R0 != 0) && (rd_addr == '0))) begin
      if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr))
        rd_val = WIDTH'(byte_merge(MAX_W'(mem_word), MAX_W'(wr_din), MAX_NBE'(wr_be)));
      else
        rd_val = mem_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_val;
  end

  assign rd_dout = (REG_RD != 0) ? rd_q : rd_val;

endmodule

// File: rtl/memblock_mp.sv
// Multi-read, single-write memory with byte enables and a self-clearing sweep after reset.
//   state | meaning
//   CLEAR | zeroing mem[clr_addr] each cycle; writes ignored, reads return 0
//   RUN   | normal operation, ready=1
module memblock_mp
  import memblock_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int NBE     = WIDTH / 8,
  parameter int REG_RD  = 0,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_dout,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_din,
  input  logic [NBE-1:0]       wr_be,
  output logic                 ready
);

  state_e           state;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_in_rng;
  logic             wr_ok;
  logic             clear;

  if (DEPTH == (1 << AW)) begin : g_wfull
    assign wr_in_rng = 1'b1;
  end else begin : g_wpart
    assign wr_in_rng = (32'(wr_addr) < DEPTH);
  end

  assign clear = (state == CLEAR);
  assign wr_ok = we && !clear && wr_in_rng && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == AW'(DEPTH - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage has no reset of its own; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        for (int b = 0; b < NBE; b++) begin
          if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_din[8*b +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    memblock_mp_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .NBE    (NBE),
      .REG_RD (REG_RD),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_rdport (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .rd_addr (rd_addr[k*AW +: AW]),
      .mem_word(mem[rd_addr[k*AW +: AW]]),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_din  (wr_din),
      .wr_be   (wr_be),
      .rd_dout (rd_dout[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_memblock_mp.sv
// Directed bench: three instances (comb/bypass, registered/read-first, DEPTH=20) on shared stimulus.
module tb_memblock_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_din;
  logic [3:0]  wr_be;
  logic [63:0] rd_a, rd_b, rd_c;
  logic        ready_a, ready_b, ready_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memblock_mp #(.DEPTH(32), .REG_RD(0), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(rd_a), .we(we),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be), .ready(ready_a));

  memblock_mp #(.DEPTH(32), .REG_RD(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(rd_b), .we(we),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be), .ready(ready_b));

  memblock_mp #(.DEPTH(20), .REG_RD(0), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(rd_c), .we(we),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be), .ready(ready_c));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_c(input int a);
    case (a)
      1:       return 32'h0000_5678;
      5:       return 32'hAA22_CC44;
      7:       return 32'h0000_0009;
      19:      return 32'hCAFE_F00D;
      default: return 32'h0;
    endcase
  endfunction

  // Counts edges after reset release until each instance raises ready.
  task automatic sweep(input string tag, input bit poke);
    int ra, rb, rc;
    ra = 0; rb = 0; rc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_a && ra == 0) ra = i;
      if (ready_b && rb == 0) rb = i;
      if (ready_c && rc == 0) rc = i;
      if (poke && i == 9) begin
        we = 1'b1; wr_addr = 5'd3; wr_din = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_addr = {5'd3, 5'd3};
      end
      if (poke && i == 10) begin
        we = 1'b0;
        chk({tag, "_clear_rd"}, rd_a, 64'h0);
      end
    end
    chk({tag, "_ready_a"}, 64'(ra), 64'd32);
    chk({tag, "_ready_b"}, 64'(rb), 64'd32);
    chk({tag, "_ready_c"}, 64'(rc), 64'd20);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      tick();
      chk({tag, "_zero_a"}, rd_a, 64'h0);
      chk({tag, "_zero_b"}, rd_b, 64'h0);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hAABB_CCDD, 4'hF, 5'd5, 5'd5, 32'hAABB_CCDD, 32'hAABB_CCDD};
    tbl[1]  = '{1'b1, 5'd5, 32'h1122_3344, 4'h5, 5'd5, 5'd5, 32'hAA22_CC44, 32'hAA22_CC44};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,         4'h0, 5'd5, 5'd5, 32'hAA22_CC44, 32'hAA22_CC44};
    tbl[3]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 5'd0, 5'd1, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 5'd1, 32'h1234_5678, 4'h3, 5'd0, 5'd1, 32'h0,         32'h0000_5678};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,         4'h0, 5'd0, 5'd1, 32'h0,         32'h0000_5678};
    tbl[6]  = '{1'b1, 5'd7, 32'h0000_0001, 4'hF, 5'd7, 5'd5, 32'h0000_0001, 32'hAA22_CC44};
    tbl[7]  = '{1'b1, 5'd7, 32'h0000_0009, 4'hF, 5'd7, 5'd7, 32'h0000_0009, 32'h0000_0009};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,         4'h0, 5'd7, 5'd1, 32'h0000_0009, 32'h0000_5678};
    tbl[9]  = '{1'b1, 5'd9, 32'hDEAD_BEEF, 4'h0, 5'd9, 5'd9, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,         4'h0, 5'd9, 5'd7, 32'h0,         32'h0000_0009};

    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_ready", {61'h0, ready_a, ready_b, ready_c}, 64'h0);
    chk("rst_rd_b", rd_b, 64'h0);
    chk("rst_rd_a", rd_a, 64'h0);
    rst = 1'b0;

    sweep("init", 1'b1);
    all_zero("init");

    // Table vectors checked against the combinational/bypass instance.
    for (int v = 0; v < 11; v++) begin
      we = tbl[v].we; wr_addr = tbl[v].wa; wr_din = tbl[v].wd; wr_be = tbl[v].be;
      rd_addr = {tbl[v].ra1, tbl[v].ra0};
      #2;
      chk($sformatf("tbl%0d", v), rd_a, {tbl[v].e1, tbl[v].e0});
      tick();
    end
    we = 1'b0;

    // Same-cycle write/read of addr 7: bypass vs read-first registered.
    we = 1'b1; wr_addr = 5'd7; wr_din = 32'h1; wr_be = 4'hF; rd_addr = {5'd7, 5'd7};
    tick();
    wr_din = 32'h9;
    #2;
    chk("byp_comb", rd_a, {32'h9, 32'h9});
    tick();
    chk("rdfirst_old", rd_b, {32'h1, 32'h1});
    we = 1'b0;
    tick();
    chk("rdfirst_new", rd_b, {32'h9, 32'h9});

    // DEPTH=20: out-of-range write dropped, addr 19 keeps its value.
    we = 1'b1; wr_addr = 5'd19; wr_din = 32'hCAFE_F00D; wr_be = 4'hF;
    tick();
    wr_addr = 5'd25; wr_din = 32'h5555_5555; rd_addr = {5'd19, 5'd25};
    #2;
    chk("d20_oor", rd_c, {32'hCAFE_F00D, 32'h0});
    tick();
    we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_addr = {5'd25, 5'(i)};
      #2;
      chk($sformatf("d20_addr%0d", i), rd_c, {32'h0, exp_c(i)});
      tick();
    end

    // Fill, then reset mid-operation.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr_addr = 5'(i); wr_din = 32'(i * 3); wr_be = 4'hF;
      tick();
    end
    we = 1'b0;
    rd_addr = {5'd19, 5'd31};
    #2;
    chk("fill_a", rd_a, {32'd57, 32'd93});
    chk("fill_c", rd_c, {32'd57, 32'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {61'h0, ready_a, ready_b, ready_c}, 64'h0);
    sweep("mid", 1'b0);
    all_zero("mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
